aes_key_expand_fwd: RTL and testbench

- Forward AES-128 key-schedule engine, the write side of the round-key store that the decryption datapath reads.
- Accepts the cipher key and iterates the forward expansion, one round key per clock.
- Stores all 11 round keys in an internal buffer.
- Provides a registered random-access read port, so the inverse cipher can consume keys in reverse order (10 down to 0).

---
 rtl/aes_pkg.sv | 36 +++
 rtl/aes_sub_word.sv | 14 +
 rtl/aes_key_expand_fwd.sv | 116 +++++++++++
 tb/tb_aes_key_expand_fwd.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, round count, key/word types, GF(2^8) doubling.
// Used by both the forward key schedule and the inverse-cipher datapath.
package aes_pkg;

  localparam int NR = 10;

  typedef logic [127:0] round_key_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Multiply by x in GF(2^8), reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: byte-wise S-box substitution of a 32-bit word (purely combinational).
module aes_sub_word
  import aes_pkg::*;
(
  input  word_t w_i,
  output word_t w_o
);

  assign w_o[31:24] = SBOX[w_i[31:24]];
  assign w_o[23:16] = SBOX[w_i[23:16]];
  assign w_o[15:8]  = SBOX[w_i[15:8]];
  assign w_o[7:0]   = SBOX[w_i[7:0]];

endmodule

// File: rtl/aes_key_expand_fwd.sv
// Forward AES-128 key schedule: one round key per clock into an 11-entry buffer,
// with a registered random-access read port for reverse-order consumption.
module aes_key_expand_fwd
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  output logic             busy,
  output logic             keys_valid,
  input  logic             rd_en,
  input  logic [3:0]       rd_idx,
  output logic [KEY_W-1:0] rd_data,
  output logic             rd_vld
);

  if (NR != 10 || KEY_W != 128) begin : g_param_check
    $error("aes_key_expand_fwd supports AES-128 only (NR=10, KEY_W=128)");
  end

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  round_key_t w_q, w_d;
  round_key_t key_buf_q [NR+1];
  round_key_t rd_data_q;
  logic       rd_vld_q;

  logic       buf_we;
  logic [3:0] buf_widx;
  round_key_t buf_wdata;

  word_t      w3_rot, w3_sub, t_word;
  word_t      n0, n1, n2, n3;
  round_key_t next_key;

  assign w3_rot = {w_q[23:0], w_q[31:24]};

  aes_sub_word u_sub_word (
    .w_i (w3_rot),
    .w_o (w3_sub)
  );

  assign t_word   = w3_sub ^ {rcon_q, 24'h0};
  assign n0       = w_q[127:96] ^ t_word;
  assign n1       = w_q[95:64]  ^ n0;
  assign n2       = w_q[63:32]  ^ n1;
  assign n3       = w_q[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_comb begin
    state_d   = state_q;
    round_d   = round_q;
    rcon_d    = rcon_q;
    w_d       = w_q;
    buf_we    = 1'b0;
    buf_widx  = round_q;
    buf_wdata = next_key;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          buf_we    = 1'b1;
          buf_widx  = 4'd0;
          buf_wdata = key_in;
          w_d       = key_in;
          round_d   = 4'd1;
          rcon_d    = 8'h01;
          state_d   = EXPAND;
        end
      end
      EXPAND: begin
        // start is deliberately ignored here; an expansion always runs to completion
        buf_we  = 1'b1;
        w_d     = next_key;
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        if (round_q == 4'(NR)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      round_q   <= 4'd0;
      rcon_q    <= 8'h01;
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      rcon_q    <= rcon_d;
      rd_vld_q  <= rd_en;
      if (rd_en) rd_data_q <= (rd_idx <= 4'(NR)) ? key_buf_q[rd_idx] : '0;
    end
  end

  // Working words and key storage are not reset; rst only blocks new writes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_q <= w_d;
      if (buf_we) key_buf_q[buf_widx] <= buf_wdata;
    end
  end

  assign busy       = (state_q == EXPAND);
  assign keys_valid = (state_q == DONE);
  assign rd_data    = rd_data_q;
  assign rd_vld     = rd_vld_q;

endmodule

// File: tb/tb_aes_key_expand_fwd.sv
// Directed bench for aes_key_expand_fwd using FIPS-197 and all-zero key schedules.
module tb_aes_key_expand_fwd;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst, start, rd_en;
  logic [127:0] key_in;
  logic [3:0]   rd_idx;
  logic         busy, keys_valid, rd_vld;
  logic [127:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  vec_t fips_v [11];
  vec_t zero_v [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  aes_key_expand_fwd dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_in     (key_in),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rd_en      (rd_en),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .rd_vld     (rd_vld)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [3:0] idx, input logic [127:0] exp);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick;
    rd_en  = 1'b0;
    chk({name, "_vld"}, 128'(rd_vld), 128'd1);
    chk(name, rd_data, exp);
  endtask

  task automatic pulse_start(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    tick;
    start  = 1'b0;
  endtask

  // Called just after E0; checks keys_valid first appears at E0+10.
  task automatic wait_valid(input string name, input int already);
    int n;
    n = already;
    while (!keys_valid && n < 40) begin
      tick;
      n++;
    end
    chk(name, 128'(n), 128'd10);
  endtask

  task automatic check_table(input string name, input bit use_zero);
    for (int i = 0; i < 11; i++) begin
      if (use_zero) rd_check($sformatf("%s_k%0d", name, zero_v[i].idx), zero_v[i].idx, zero_v[i].exp);
      else          rd_check($sformatf("%s_k%0d", name, fips_v[i].idx), fips_v[i].idx, fips_v[i].exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    fips_v[0]  = '{4'd0,  FIPS_KEY};
    fips_v[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
    fips_v[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
    fips_v[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
    fips_v[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
    fips_v[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    fips_v[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
    fips_v[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    fips_v[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
    fips_v[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
    fips_v[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    zero_v[0]  = '{4'd0,  128'h0};
    zero_v[1]  = '{4'd1,  128'h62636363626363636263636362636363};
    zero_v[2]  = '{4'd2,  128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};
    zero_v[3]  = '{4'd3,  128'h90973450696ccffaf2f457330b0fac99};
    zero_v[4]  = '{4'd4,  128'hee06da7b876a1581759e42b27e91ee2b};
    zero_v[5]  = '{4'd5,  128'h7f2e2b88f8443e098dda7cbbf34b9290};
    zero_v[6]  = '{4'd6,  128'hec614b851425758c99ff09376ab49ba7};
    zero_v[7]  = '{4'd7,  128'h217517873550620bacaf6b3cc61bf09b};
    zero_v[8]  = '{4'd8,  128'h0ef903333ba9613897060a04511dfa9f};
    zero_v[9]  = '{4'd9,  128'hb1d4d8e28a7db9da1d7bb3de4c664941};
    zero_v[10] = '{4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    rst = 1'b1; start = 1'b0; rd_en = 1'b0; rd_idx = 4'd0; key_in = '0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_busy",  128'(busy),       128'd0);
    chk("rst_valid", 128'(keys_valid), 128'd0);
    chk("rst_rdvld", 128'(rd_vld),     128'd0);
    chk("rst_rdata", rd_data,          128'd0);

    // FIPS-197 key: busy for exactly 10 cycles
    pulse_start(FIPS_KEY);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("fips_busy_%0d", i),  128'(busy),       128'd1);
      chk($sformatf("fips_nval_%0d", i),  128'(keys_valid), 128'd0);
      tick;
    end
    chk("fips_busy_end", 128'(busy),       128'd0);
    chk("fips_valid",    128'(keys_valid), 128'd1);
    check_table("fips", 1'b0);

    // Reverse sweep with rd_en held high
    rd_en  = 1'b1;
    rd_idx = 4'd10;
    for (int i = 0; i < 11; i++) begin
      tick;
      chk($sformatf("sweep_vld_%0d", 10 - i), 128'(rd_vld), 128'd1);
      chk($sformatf("sweep_k%0d", 10 - i), rd_data, fips_v[10 - i].exp);
      if (i < 10) rd_idx = 4'(9 - i);
      else        rd_en  = 1'b0;
    end
    tick;
    chk("sweep_vld_off", 128'(rd_vld), 128'd0);

    // All-zero key, restarted from DONE, with a FIPS start pulse at E0+4 ignored
    pulse_start(128'h0);
    tick; tick; tick;
    start  = 1'b1;
    key_in = FIPS_KEY;
    tick;
    start  = 1'b0;
    repeat (5) tick;
    chk("mid_nval_e9", 128'(keys_valid), 128'd0);
    tick;
    chk("mid_valid_e10", 128'(keys_valid), 128'd1);
    chk("mid_busy_e10",  128'(busy),       128'd0);
    check_table("zero", 1'b1);
    rd_check("oob_15", 4'd15, 128'h0);
    rd_check("oob_11", 4'd11, 128'h0);

    // Reset at E0+5 aborts; a fresh expansion must fully rebuild the buffer
    pulse_start(FIPS_KEY);
    repeat (4) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_busy",  128'(busy),       128'd0);
    chk("abort_valid", 128'(keys_valid), 128'd0);
    pulse_start(128'h0);
    wait_valid("abort_restart_lat", 0);
    check_table("rezero", 1'b1);

    // Restart from DONE with a new key; a read of key 1 at E0+1 returns old contents
    start  = 1'b1;
    key_in = FIPS_KEY;
    tick;
    start  = 1'b0;
    chk("restart_nval", 128'(keys_valid), 128'd0);
    chk("restart_busy", 128'(busy),       128'd1);
    rd_en  = 1'b1;
    rd_idx = 4'd1;
    tick;
    rd_en  = 1'b0;
    chk("rbw_vld", 128'(rd_vld), 128'd1);
    chk("rbw_k1",  rd_data,      zero_v[1].exp);
    wait_valid("restart_lat", 1);
    check_table("refips", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
